// File: rtl/serial_arith_pkg.sv
// Shared types for the bit-serial arithmetic blocks: FSM state encoding and mode constants.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder: s_o, c_o from a_i + b_i + c_i.
// Latency: purely combinational. Backpressure: none.
module fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit add/subtract, LSB first, one bit per clock through a single full adder.
// Latency: done in the cycle after edge k+WIDTH for a start accepted at edge k; one result per WIDTH+1 cycles.
// Backpressure: start is accepted only while ready (IDLE or DONE); start during RUN is dropped.
module serial_addsub
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               fa_s, fa_co;

    fa_cell u_fa (
        .a_i (opa_q[0]),
        .b_i (opb_q[0]),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_co)
    );

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            RUN: begin
                opa_d   = opa_q >> 1;
                opb_d   = opb_q >> 1;
                res_d   = {fa_s, res_q[WIDTH-1:1]};
                carry_d = fa_co;
                cnt_d   = cnt_q + CNT_W'(1);
                // On the MSB, carry_q is still the carry into the MSB.
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    sum_d   = res_d;
                    cout_d  = fa_co;
                    ovf_d   = carry_q ^ fa_co;
                end
            end
            default: begin
                if (start) begin
                    state_d = RUN;
                    opa_d   = a;
                    opb_d   = (sub == MODE_SUB) ? ~b : b;
                    carry_d = sub;
                    cnt_d   = '0;
                    res_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ready    = (state_q != RUN);
    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign sum      = sum_q;
    assign c_out    = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed table, handshake and reset-abort checks on an 8-bit instance, plus random sweeps at widths 2, 8 and 33.
module tb_serial_addsub;

    typedef struct packed {
        logic [63:0] s;
        logic        c;
        logic        v;
    } res_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [7:0] s;
        logic       c;
        logic       v;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int sweeps_fin = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Signed overflow judged from operand/result signs rather than MSB carries.
    function automatic res_t ref_calc(input int w, input logic [63:0] x, input logic [63:0] y, input logic sb);
        logic [63:0] mask, xx, yy;
        logic [64:0] full;
        res_t r;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        xx   = x & mask;
        yy   = (sb ? ~y : y) & mask;
        full = {1'b0, xx} + {1'b0, yy} + 65'(sb);
        r.s  = full[63:0] & mask;
        r.c  = full[w];
        r.v  = (xx[w-1] == yy[w-1]) && (r.s[w-1] != xx[w-1]);
        return r;
    endfunction

    // 8-bit directed instance
    logic       rst8, start8, sub8;
    logic [7:0] a8, b8, sum8;
    logic       ready8, busy8, done8, cout8, ovf8;

    serial_addsub #(.WIDTH(8)) u_dut (
        .clk      (clk),
        .rst      (rst8),
        .start    (start8),
        .a        (a8),
        .b        (b8),
        .sub      (sub8),
        .ready    (ready8),
        .busy     (busy8),
        .done     (done8),
        .sum      (sum8),
        .c_out    (cout8),
        .overflow (ovf8)
    );

    // Called #1 after an edge with the DUT ready; returns #1 after the edge that raises done.
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic ts, output int lat);
        a8 = ta; b8 = tb; sub8 = ts; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = ~ta; b8 = ~tb; sub8 = ~ts;
        lat = -1;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk); #1;
            if (done8) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        vec_t   vt[10];
        res_t   r;
        int     lat, ndone;
        logic [7:0] ha[27], hb[27];
        logic       hs[27];

        vt[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
        vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vt[3] = '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};
        vt[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
        vt[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[6] = '{8'h55, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
        vt[7] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vt[8] = '{8'h01, 8'h80, 1'b1, 8'h81, 1'b0, 1'b1};
        vt[9] = '{8'hFF, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};

        rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst8 = 1'b0;
        chk("rst_ready", 64'(ready8), 64'd1);
        chk("rst_busy",  64'(busy8),  64'd0);
        chk("rst_done",  64'(done8),  64'd0);
        chk("rst_sum",   64'(sum8),   64'd0);
        chk("rst_cout",  64'(cout8),  64'd0);
        chk("rst_ovf",   64'(ovf8),   64'd0);

        // Table: done is visible after WIDTH edges past the accept edge.
        for (int i = 0; i < 10; i++) begin
            run8(vt[i].a, vt[i].b, vt[i].sub, lat);
            chk("tbl_latency", 64'(lat), 64'd8);
            chk("tbl_sum",  64'(sum8), 64'(vt[i].s));
            chk("tbl_cout", 64'(cout8), 64'(vt[i].c));
            chk("tbl_ovf",  64'(ovf8), 64'(vt[i].v));
            if (i == 0) begin
                @(posedge clk); #1;
                chk("done_width", 64'(done8), 64'd0);
                chk("idle_ready", 64'(ready8), 64'd1);
                chk("held_sum", 64'(sum8), 64'h96);
            end
        end

        // Handshake: start held high with operands changing every cycle.
        start8 = 1'b1;
        for (int e = 0; e < 27; e++) begin
            ha[e] = 8'(e * 13 + 5);
            hb[e] = 8'(e * 29 + 7);
            hs[e] = e[0];
            a8 = ha[e]; b8 = hb[e]; sub8 = hs[e];
            @(posedge clk); #1;
            chk("hs_done", 64'(done8), 64'((e % 9) == 8));
            chk("hs_busy", 64'(busy8), 64'((e % 9) != 8));
            if ((e % 9) == 8) begin
                r = ref_calc(8, 64'(ha[e-8]), 64'(hb[e-8]), hs[e-8]);
                chk("hs_sum",  64'(sum8), r.s);
                chk("hs_cout", 64'(cout8), 64'(r.c));
                chk("hs_ovf",  64'(ovf8), 64'(r.v));
            end
        end
        start8 = 1'b0;
        @(posedge clk); #1;
        chk("hs_idle", 64'(ready8 && !done8), 64'd1);

        // Reset mid-run: results from a prior op must be cleared, no done issued.
        run8(8'hFF, 8'h80, 1'b0, lat);
        chk("pre_sum", 64'({cout8, ovf8, sum8}), 64'h37F);
        @(posedge clk); #1;
        a8 = 8'hAA; b8 = 8'h55; sub8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst8 = 1'b1;
        @(posedge clk); #1;
        rst8 = 1'b0;
        chk("abort_ready", 64'(ready8), 64'd1);
        chk("abort_busy",  64'(busy8),  64'd0);
        chk("abort_done",  64'(done8),  64'd0);
        chk("abort_sum",   64'(sum8),   64'd0);
        chk("abort_cout",  64'(cout8),  64'd0);
        chk("abort_ovf",   64'(ovf8),   64'd0);
        ndone = 0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            if (done8) ndone++;
        end
        chk("abort_no_done", 64'(ndone), 64'd0);
        run8(8'h01, 8'h01, 1'b0, lat);
        chk("post_latency", 64'(lat), 64'd8);
        chk("post_sum", 64'({cout8, ovf8, sum8}), 64'h002);

        for (int i = 0; i < 60000 && sweeps_fin < 3; i++) @(posedge clk);
        chk("sweeps_finished", 64'(sweeps_fin), 64'd3);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    // Random sweeps, one independent instance per width.
    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int W = (g == 0) ? 2 : (g == 1) ? 8 : 33;

        logic         rst_s, start_s, sub_s;
        logic [W-1:0] a_s, b_s, sum_s;
        logic         ready_s, busy_s, done_s, cout_s, ovf_s;

        serial_addsub #(.WIDTH(W)) u_dut (
            .clk      (clk),
            .rst      (rst_s),
            .start    (start_s),
            .a        (a_s),
            .b        (b_s),
            .sub      (sub_s),
            .ready    (ready_s),
            .busy     (busy_s),
            .done     (done_s),
            .sum      (sum_s),
            .c_out    (cout_s),
            .overflow (ovf_s)
        );

        initial begin
            res_t        r;
            int          lat;
            logic [63:0] ra, rb;
            logic        rs;

            rst_s = 1'b1; start_s = 1'b0; a_s = '0; b_s = '0; sub_s = 1'b0;
            repeat (2) @(posedge clk);
            #1 rst_s = 1'b0;
            for (int i = 0; i < 1000; i++) begin
                ra = {$urandom, $urandom};
                rb = {$urandom, $urandom};
                rs = 1'($urandom_range(0, 1));
                a_s = W'(ra); b_s = W'(rb); sub_s = rs; start_s = 1'b1;
                @(posedge clk); #1;
                start_s = 1'b0; a_s = ~a_s; sub_s = ~rs;
                lat = -1;
                for (int n = 1; n <= W + 4; n++) begin
                    @(posedge clk); #1;
                    if (done_s) begin
                        lat = n;
                        break;
                    end
                end
                r = ref_calc(W, ra, rb, rs);
                chk("sw_latency", 64'(lat), 64'(W));
                chk("sw_sum",  64'(sum_s), r.s);
                chk("sw_cout", 64'(cout_s), 64'(r.c));
                chk("sw_ovf",  64'(ovf_s), 64'(r.v));
                @(posedge clk); #1;
                chk("sw_done_width", 64'(done_s), 64'd0);
            end
            sweeps_fin++;
        end
    end

endmodule
